// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction types, the HALT encoding and the fetch state encoding.
package isa_pkg;

   typedef enum logic [1:0] {
      INSTR_R = 2'b00,
      INSTR_M = 2'b01,
      INSTR_B = 2'b10,
      INSTR_S = 2'b11
   } instr_type_e;

   // M-type no-op encoding reused as the program terminator
   localparam logic [8:0] HALT_INSTR = 9'h0FF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target lookup table: synchronous write, asynchronous read, cleared by synchronous reset.
module branch_lut #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 10
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   // NOTE: clearing every entry on reset keeps this as flops rather than a RAM macro;
   // the table is small and a known-zero target after reset is part of the contract.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read sees the pre-edge contents, so a same-cycle write returns the old target.
   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / sequencing stage: PC, run/halt FSM and branch-target LUT.
// Optional FETCH_CYCLE_COUNT_EN adds a saturating 32-bit RUN-cycle counter output.
module fetch_unit
   import isa_pkg::*;
#(
   parameter int PC_WIDTH    = 10,
   parameter int LUT_DEPTH   = 32,
   parameter int INSTR_WIDTH = 9
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   output logic                         done,
   input  logic                         stall,
   output logic [PC_WIDTH-1:0]          instr_addr,
   input  logic [INSTR_WIDTH-1:0]       instr_rdata,
   output logic [INSTR_WIDTH-1:0]       instr_bits,
   output logic                         instr_valid,
   input  logic                         branch,
   input  logic [$clog2(LUT_DEPTH)-1:0] lut_index,
   input  logic                         lut_wr_en,
   input  logic [$clog2(LUT_DEPTH)-1:0] lut_wr_addr,
   input  logic [PC_WIDTH-1:0]          lut_wr_data
`ifdef FETCH_CYCLE_COUNT_EN
   ,
   output logic [31:0]                  cycle_count
`endif
);

   fetch_state_e        state;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] lut_target;
   logic                is_halt;

   branch_lut #(
      .DEPTH (LUT_DEPTH),
      .AW    ($clog2(LUT_DEPTH)),
      .DW    (PC_WIDTH)
   ) u_lut (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (lut_wr_en),
      .wr_addr (lut_wr_addr),
      .wr_data (lut_wr_data),
      .rd_addr (lut_index),
      .rd_data (lut_target)
   );

   assign is_halt = (instr_rdata == INSTR_WIDTH'(HALT_INSTR));

   // NOTE: all state is updated with non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         pc    <= '0;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state <= ST_RUN;
                  pc    <= '0;
                  done  <= 1'b0;
               end
            end
            ST_RUN: begin
               // Stall outranks both HALT detection and branching.
               if (!stall) begin
                  if (is_halt) begin
                     state <= ST_HALT;
                     done  <= 1'b1;
                  end else if (branch) begin
                     pc <= lut_target;
                  end else begin
                     pc <= pc + PC_WIDTH'(1);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Decode loop stays combinational so a branch lands on the very next cycle.
   assign instr_addr  = pc;
   assign instr_bits  = (state == ST_RUN) ? instr_rdata : '0;
   assign instr_valid = (state == ST_RUN) && !stall;

`ifdef FETCH_CYCLE_COUNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cycle_count <= '0;
      end else if ((state != ST_RUN) && start) begin
         cycle_count <= '0;
      end else if ((state == ST_RUN) && (cycle_count != '1)) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`endif

endmodule
